alu_exec_unit: RTL

Handshaked, multi-cycle execution unit that consumes the 3-bit ALU control code produced by the ALU control decoder and performs the selected operation on two operands. It sits in the execute stage between operand fetch and writeback. A valid/ready handshake on each side lets the rest of the pipeline stall on long shift operations.

---
 rtl/alu_exec_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked multi-cycle ALU execution unit
//
// Executes one ALU operation per accepted request and presents a registered
// result behind a valid/ready handshake. Shifts are iterative (one bit per
// cycle) by default. Defining FAST_SHIFT_EN replaces them with a single-cycle
// barrel shifter. Results are identical in both builds; only latency differs.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     request valid
//   in_ready     unit can accept a request (high only in IDLE)
//   alu_control  op code: 000 ADD, 001 SUB, 010 AND, 011 OR,
//                100 XOR, 101 SLT, 110 SLL, 111 SRL
//   src_a        operand A
//   src_b        operand B; shift amount is src_b[SHW-1:0]
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts result
//   result       registered result
//   zero         registered flag, 1 when result == 0

module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

`ifdef FAST_SHIFT_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DONE  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_accept;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_result;

    assign w_accept = in_valid & in_ready;
    assign w_shamt  = src_b[SHW-1:0];
    assign result   = r_result;
    assign zero     = r_zero;

`ifndef FAST_SHIFT_EN
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_shift_right;   // direction latched at acceptance
    logic             w_is_shift;
    logic             w_shift_nonzero;
    logic [WIDTH-1:0] w_acc_shifted;

    assign w_is_shift      = (alu_control == OP_SLL) || (alu_control == OP_SRL);
    assign w_shift_nonzero = w_is_shift && (w_shamt != '0);
    assign w_acc_shifted   = r_shift_right ? (r_acc >> 1) : (r_acc << 1);
`endif

    // Combinational ALU. In the iterative build the shift ops yield src_a
    // here, which is exactly the amount-0 result; nonzero amounts take the
    // SHIFT path and never use this value.
    always_comb begin
        w_alu_result = '0;
        case (alu_control)
            OP_ADD: w_alu_result = src_a + src_b;
            OP_SUB: w_alu_result = src_a - src_b;
            OP_AND: w_alu_result = src_a & src_b;
            OP_OR:  w_alu_result = src_a | src_b;
            OP_XOR: w_alu_result = src_a ^ src_b;
            OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef FAST_SHIFT_EN
            OP_SLL: w_alu_result = src_a << w_shamt;
            OP_SRL: w_alu_result = src_a >> w_shamt;
`else
            OP_SLL: w_alu_result = src_a;
            OP_SRL: w_alu_result = src_a;
`endif
            default: w_alu_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef FAST_SHIFT_EN
                    w_next_state = S_DONE;
`else
                    w_next_state = w_shift_nonzero ? S_SHIFT : S_DONE;
`endif
                end
            end
`ifndef FAST_SHIFT_EN
            S_SHIFT: begin
                if (r_cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
                    w_next_state = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs are pure functions of state, so a request can never
    // be accepted in the same cycle as a result handoff.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

`ifdef FAST_SHIFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_result <= w_alu_result;
            r_zero   <= (w_alu_result == '0);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_shift_right <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift) begin
                            r_acc         <= src_a;
                            r_cnt         <= w_shamt;
                            r_shift_right <= alu_control[0];
                        end
                        if (!w_shift_nonzero) begin
                            r_result <= w_alu_result;
                            r_zero   <= (w_alu_result == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_shifted;
                    r_cnt <= r_cnt - {{(SHW-1){1'b0}}, 1'b1};
                    // Last step: publish the final shifted value.
                    if (r_cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
                        r_result <= w_acc_shifted;
                        r_zero   <= (w_acc_shifted == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule
